// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 data-memory responder: word/lane
// widths and the responder FSM state encoding.
package mips32_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed data RAM: 2**ADDR_W x 32 bits, one port with a
// synchronous read and per-byte-lane write enables.
module dmem_bank
  import mips32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLOCK_50,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Byte-lane merge on write, registered read; read data holds until the next read.
  // NOTE: the array has no reset branch on purpose -- clearing a RAM needs a
  // per-word loop that defeats block-RAM inference, and contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the multicycle mips32 core. Accepts one
// load/store word request at a time, inserts WAIT_STATES idle cycles,
// performs the RAM access, then holds the response until the core takes it.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject non-word-aligned
// requests with rsp_err=1 (no RAM access, same latency).
module mips_dmem_responder
  import mips32_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Counter preload so that WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t       state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              err_q, err_d;          // captured request is misaligned
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_load_q, rsp_load_d; // response carries bank read data

  logic              bank_we;
  logic              bank_re;
  logic [WORD_W-1:0] bank_rdata;
  logic              req_misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_misaligned = (req_addr[1:0] != 2'b00);
`else
  // Byte offset has no meaning without the alignment check.
  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[1:0];
  assign req_misaligned     = 1'b0;
`endif

  // Next-state, request capture and response bookkeeping.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    bank_we    = 1'b0;
    bank_re    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr[ADDR_W+1:2];
          wdata_d    = req_wdata;
          be_d       = req_be;
          err_d      = req_misaligned;
          wait_cnt_d = WAIT_INIT;
          state_d    = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        bank_we    = we_q && !err_q;
        bank_re    = !we_q && !err_q;
        rsp_err_d  = err_q;
        rsp_load_d = !we_q && !err_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d  = 1'b0;
          rsp_load_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset; RAM is untouched.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      err_q      <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      err_q      <= err_d;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
    end
  end

  dmem_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .CLOCK_50 (CLOCK_50),
    .we       (bank_we),
    .re       (bank_re),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .be       (be_q),
    .rdata    (bank_rdata)
  );

  // The bank's read register only updates in ACCESS, so gating it keeps
  // rsp_rdata stable through RESP and zero everywhere else.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_load_q ? bank_rdata : '0;
  assign rsp_err   = rsp_err_q;

endmodule
